// File: rtl/clkg_pkg.sv
// rtl/clkg_pkg.sv - shared types and widths for the clkg sequencer
package clkg_pkg;

   // divider code width (0 = /2 ... 7 = /256)
   localparam int DIV_W  = 3;
   // branch gate vector width, ordered {msk, ncm, smp}
   localparam int GATE_W = 3;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_GOFF   = 3'd1,
      ST_COFF   = 3'd2,
      ST_SWITCH = 3'd3,
      ST_SETTLE = 3'd4,
      ST_CON    = 3'd5,
      ST_GON    = 3'd6
   } seq_state_e;

   // largest of the wait lengths; the timer must be able to hold it
   function automatic int max_wait(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

endpackage

// File: rtl/clkg_seq_timer.sv
// rtl/clkg_seq_timer.sv - loadable down-counter shared by all sequencer wait states
module clkg_seq_timer #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   output logic             zero_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // next count: load wins, otherwise count down and park at zero
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   // counter register
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/clkg_seq.sv
// rtl/clkg_seq.sv - glitch-safe clock config sequencer driving the clkg controls
module clkg_seq
   import clkg_pkg::*;
#(
   parameter int GATE_WAIT   = 4,
   parameter int CLK_WAIT    = 8,
   parameter int DIV_RST_CYC = 2,
   parameter int OSC_SETTLE  = 64,
   parameter int CNT_W       = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_req,
   input  logic             i_cfg_osc,
   input  logic [DIV_W-1:0] i_cfg_div,
   input  logic [GATE_W-1:0] i_cfg_gates,
   output logic             o_ready,
   output logic             o_done,
   output logic             o_osc_en,
   output logic             o_clk_en,
   output logic [DIV_W-1:0] o_clk_div,
   output logic             o_smp_en,
   output logic             o_ncm_en,
   output logic             o_msk_en,
   output logic             o_div_rst_n
);

   // a zero wait would collapse a safety interval, so refuse to elaborate
   if (GATE_WAIT < 1 || CLK_WAIT < 1 || DIV_RST_CYC < 1 || OSC_SETTLE < 1) begin : g_bad_wait
      $error("clkg_seq: all wait parameters must be at least 1");
   end
   if (max_wait(GATE_WAIT, CLK_WAIT, DIV_RST_CYC, OSC_SETTLE) > (1 << CNT_W)) begin : g_bad_cnt_w
      $error("clkg_seq: CNT_W too narrow for the longest wait");
   end

   // timer is loaded with wait-1 so the state lasts exactly 'wait' cycles
   localparam logic [CNT_W-1:0] GATE_LD   = CNT_W'(GATE_WAIT - 1);
   localparam logic [CNT_W-1:0] CLK_LD    = CNT_W'(CLK_WAIT - 1);
   localparam logic [CNT_W-1:0] DRST_LD   = CNT_W'(DIV_RST_CYC - 1);
   localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(OSC_SETTLE - 1);

   seq_state_e        state_q;
   seq_state_e        state_d;
   logic              shd_osc_q;
   logic [DIV_W-1:0]  shd_div_q;
   logic [GATE_W-1:0] shd_gates_q;
   logic              src_chg_q;

   logic              accept;
   logic              gates_only;
   logic              tmr_load;
   logic [CNT_W-1:0]  tmr_val;
   logic              tmr_zero;

   assign accept     = i_req & o_ready;
   // clock already running on the requested source/divider: only gates move
   assign gates_only = (i_cfg_osc == o_osc_en) && (i_cfg_div == o_clk_div) && o_clk_en;

   clkg_seq_timer #(
      .CNT_W(CNT_W)
   ) u_timer (
      .clk       (clk),
      .rst       (rst),
      .load_i    (tmr_load),
      .load_val_i(tmr_val),
      .zero_o    (tmr_zero)
   );

   // next state and timer reload on every state entry
   always_comb begin
      state_d  = state_q;
      tmr_load = 1'b0;
      tmr_val  = '0;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (gates_only) begin
                  state_d = ST_GON;
               end else begin
                  state_d  = ST_GOFF;
                  tmr_load = 1'b1;
                  tmr_val  = GATE_LD;
               end
            end
         end
         ST_GOFF: begin
            if (tmr_zero) begin
               state_d  = ST_COFF;
               tmr_load = 1'b1;
               tmr_val  = CLK_LD;
            end
         end
         ST_COFF: begin
            if (tmr_zero) begin
               state_d  = ST_SWITCH;
               tmr_load = 1'b1;
               tmr_val  = DRST_LD;
            end
         end
         ST_SWITCH: begin
            if (tmr_zero) begin
               tmr_load = 1'b1;
               if (src_chg_q) begin
                  state_d = ST_SETTLE;
                  tmr_val = SETTLE_LD;
               end else begin
                  state_d = ST_CON;
                  tmr_val = CLK_LD;
               end
            end
         end
         ST_SETTLE: begin
            if (tmr_zero) begin
               state_d  = ST_CON;
               tmr_load = 1'b1;
               tmr_val  = CLK_LD;
            end
         end
         ST_CON: begin
            if (tmr_zero) begin
               state_d = ST_GON;
            end
         end
         ST_GON: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // sequencer FSM with registered clkg controls; each state drives its control the cycle after entry
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         o_ready     <= 1'b1;
         o_done      <= 1'b0;
         o_osc_en    <= 1'b0;
         o_clk_en    <= 1'b0;
         o_clk_div   <= '0;
         o_smp_en    <= 1'b0;
         o_ncm_en    <= 1'b0;
         o_msk_en    <= 1'b0;
         o_div_rst_n <= 1'b0;
         shd_osc_q   <= 1'b0;
         shd_div_q   <= '0;
         shd_gates_q <= '0;
         src_chg_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         o_ready <= (state_d == ST_IDLE);
         o_done  <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               o_div_rst_n <= 1'b1;
               if (accept) begin
                  shd_osc_q   <= i_cfg_osc;
                  shd_div_q   <= i_cfg_div;
                  shd_gates_q <= i_cfg_gates;
                  src_chg_q   <= (i_cfg_osc != o_osc_en);
               end
            end
            ST_GOFF: begin
               o_smp_en <= 1'b0;
               o_ncm_en <= 1'b0;
               o_msk_en <= 1'b0;
            end
            ST_COFF: begin
               o_clk_en <= 1'b0;
            end
            ST_SWITCH: begin
               o_osc_en    <= shd_osc_q;
               o_clk_div   <= shd_div_q;
               o_div_rst_n <= 1'b0;
            end
            ST_SETTLE: begin
               o_div_rst_n <= 1'b1;
            end
            ST_CON: begin
               o_div_rst_n <= 1'b1;
               o_clk_en    <= 1'b1;
            end
            ST_GON: begin
               o_smp_en <= shd_gates_q[0];
               o_ncm_en <= shd_gates_q[1];
               o_msk_en <= shd_gates_q[2];
               o_done   <= 1'b1;
            end
            default: begin
               o_done <= 1'b0;
            end
         endcase
      end
   end

endmodule
